commutation_sequencer: RTL and testbench

Six-step commutation sequencer that sits directly downstream of the MOD-6 step counter. It registers the counter's 3-bit step value (0–5) and drives the three high-side and three low-side phase gate enables. Every pattern change passes through a programmable dead-time interval. Steps 6 and 7 are treated as invalid, so the counter's transient 3'b110 before its clear never reaches the gates.

---
 rtl/commutation_sequencer_pkg.sv | 59 +++++
 rtl/commutation_sequencer_deadtime_timer.sv | 37 +++
 rtl/commutation_sequencer.sv | 148 ++++++++++++++
 tb/tb_commutation_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commutation_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// commut_pkg
// Shared definitions for the six-step commutation sequencer:
//   - state_t      : sequencer FSM states (OFF, DEAD, RUN)
//   - PH_A/B/C     : bit index of each phase inside a 3-bit gate vector
//   - FWD_PAT      : forward {hi, lo} gate pattern for steps 0..5
//   - target_pattern(): pattern for a step/direction, all-off for steps 6/7
//   - steps_adjacent(): true when two valid steps differ by +/-1 mod 6
// -----------------------------------------------------------------------------
package commut_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int PH_A = 0;
  localparam int PH_B = 1;
  localparam int PH_C = 2;

  localparam logic [2:0] A_BIT = 3'(1 << PH_A);
  localparam logic [2:0] B_BIT = 3'(1 << PH_B);
  localparam logic [2:0] C_BIT = 3'(1 << PH_C);

  // Each entry is {hi[2:0], lo[2:0]} for forward rotation.
  localparam logic [5:0] FWD_PAT [6] = '{
    {A_BIT, B_BIT},
    {A_BIT, C_BIT},
    {B_BIT, C_BIT},
    {B_BIT, A_BIT},
    {C_BIT, A_BIT},
    {C_BIT, B_BIT}
  };

  // Reverse rotation is the forward pattern with high and low sides swapped.
  function automatic logic [5:0] target_pattern(input logic [2:0] step,
                                                input logic       dir);
    logic [5:0] p;
    p = 6'd0;
    if (step <= 3'd5) begin
      p = FWD_PAT[step];
      if (dir) begin
        p = {p[2:0], p[5:3]};
      end
    end
    return p;
  endfunction

  function automatic logic steps_adjacent(input logic [2:0] a,
                                          input logic [2:0] b);
    logic [2:0] a_inc;
    logic [2:0] b_inc;
    a_inc = (a == 3'd5) ? 3'd0 : a + 3'd1;
    b_inc = (b == 3'd5) ? 3'd0 : b + 3'd1;
    return (b == a_inc) || (a == b_inc);
  endfunction

endpackage

// File: rtl/commutation_sequencer_deadtime_timer.sv
// -----------------------------------------------------------------------------
// deadtime_timer
// Down-counter that times the all-gates-off interval between two patterns.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset (counter cleared to 0)
//   load    : reload with DEAD_CYCLES-1 (asserted on the cycle DEAD is entered)
//   expired : counter has reached 0
// With the load value DEAD_CYCLES-1, the owning FSM spends exactly
// DEAD_CYCLES cycles in DEAD: the entry cycle plus DEAD_CYCLES-1 decrements.
// -----------------------------------------------------------------------------
module deadtime_timer #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DEAD_CYCLES - 1);

  logic [CW-1:0] count_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= LOAD_VAL;
    end else if (count_r != '0) begin
      count_r <= count_r - CW'(1);
    end
  end

  assign expired = (count_r == '0);

endmodule

// File: rtl/commutation_sequencer.sv
// -----------------------------------------------------------------------------
// commutation_sequencer
// Six-step BLDC commutation sequencer fed by a MOD-6 step counter. Registers
// step/dir/en, selects the gate pattern and inserts DEAD_CYCLES of all-off
// dead time around every pattern change.
//   clk         : rising-edge clock (same clock as the step counter)
//   reset       : asynchronous active-low reset
//   en          : gate enable, low forces all gates off
//   step[2:0]   : commutation step 0..5 (6/7 are invalid and force off)
//   dir         : 0 forward, 1 reverse (hi/lo sets swapped)
//   hi[2:0]     : high-side enables, bit0=A bit1=B bit2=C
//   lo[2:0]     : low-side enables, same order
//   busy        : high while the dead-time interval is running
//   err_invalid : high while the registered step is 6 or 7
//   err_skip    : sticky non-adjacent step change flag, only present when
//                 COMMUT_SKIP_CHECK_EN is defined
// Optional feature macro: COMMUT_SKIP_CHECK_EN
// -----------------------------------------------------------------------------
module commutation_sequencer
  import commut_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] step,
  input  logic       dir,
  output logic [2:0] hi,
  output logic [2:0] lo,
  output logic       busy,
  output logic       err_invalid
`ifdef COMMUT_SKIP_CHECK_EN
  ,
  output logic       err_skip
`endif
);

  logic [2:0] step_r;
  logic       dir_r;
  logic       en_r;

  state_t     state_r;
  state_t     state_next;

  logic [2:0] hi_r;
  logic [2:0] lo_r;

  logic [5:0] target;
  logic       force_off;
  logic       timer_load;
  logic       timer_expired;

  // Input registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_r <= 3'd0;
      dir_r  <= 1'b0;
      en_r   <= 1'b0;
    end else begin
      step_r <= step;
      dir_r  <= dir;
      en_r   <= en;
    end
  end

  assign target    = target_pattern(step_r, dir_r);
  assign force_off = !en_r || (step_r > 3'd5);

  deadtime_timer #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_deadtime_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= OFF;
    end else begin
      state_r <= state_next;
    end
  end

  always_comb begin
    state_next = state_r;
    unique case (state_r)
      OFF:  state_next = DEAD;
      DEAD: if (timer_expired) state_next = RUN;
      // hi_r/lo_r hold the applied pattern while in RUN.
      RUN:  if (target != {hi_r, lo_r}) state_next = DEAD;
      default: state_next = OFF;
    endcase
    // Shutdown overrides every other transition.
    if (force_off) begin
      state_next = OFF;
    end
    // Reload only on entry; a target change inside DEAD keeps counting.
    timer_load = (state_next == DEAD) && (state_r != DEAD);
  end

  // Registered gate outputs: zero outside RUN, latched from the latest
  // target on the DEAD->RUN edge, held while RUN continues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= 3'd0;
      lo_r <= 3'd0;
    end else if (state_next != RUN) begin
      hi_r <= 3'd0;
      lo_r <= 3'd0;
    end else if (state_r != RUN) begin
      hi_r <= target[5:3];
      lo_r <= target[2:0];
    end
  end

  assign hi          = hi_r;
  assign lo          = lo_r;
  assign busy        = (state_r == DEAD);
  assign err_invalid = (step_r > 3'd5);

`ifdef COMMUT_SKIP_CHECK_EN
  logic [2:0] applied_step_r;
  logic       err_skip_r;

  // applied_step_r remembers which step the gates currently show, so a
  // change while running can be compared against it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      applied_step_r <= 3'd0;
      err_skip_r     <= 1'b0;
    end else begin
      if ((state_r == DEAD) && (state_next == RUN)) begin
        applied_step_r <= step_r;
      end
      if ((state_r == RUN) && !force_off && (step_r != applied_step_r) &&
          !steps_adjacent(applied_step_r, step_r)) begin
        err_skip_r <= 1'b1;
      end
    end
  end

  assign err_skip = err_skip_r;
`endif

endmodule

// File: tb/tb_commutation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_commutation_sequencer
// Directed scenarios followed by randomized step/dir/en traffic, compared every
// cycle against a timestamp-based reference model of the sequencer behaviour.
// -----------------------------------------------------------------------------
module tb_commutation_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] step;
  logic       dir;
  logic [2:0] hi;
  logic [2:0] lo;
  logic       busy;
  logic       err_invalid;
`ifdef COMMUT_SKIP_CHECK_EN
  logic       err_skip;
`endif

  always #5 clk = ~clk;

  commutation_sequencer #(
    .DEAD_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .step       (step),
    .dir        (dir),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .err_invalid(err_invalid)
`ifdef COMMUT_SKIP_CHECK_EN
    ,
    .err_skip   (err_skip)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         cyc = 0;
  bit         live;
  int         release_cyc;
  logic [5:0] shown;
  int         shown_step;
  bit         m_skip;
  logic [2:0] m_step;
  logic       m_dir;
  logic       m_en;

  // High phase is step/2; low phase is ((step+1)/2 + 1) mod 3.
  function automatic logic [5:0] ref_pattern(int s, bit d);
    logic [2:0] h;
    logic [2:0] l;
    h = 3'(1 << (s / 2));
    l = 3'(1 << (((s + 1) / 2 + 1) % 3));
    return d ? {l, h} : {h, l};
  endfunction

  function automatic bit ref_adjacent(int a, int b);
    return ((a - b + 6) % 6 == 1) || ((b - a + 6) % 6 == 1);
  endfunction

  task automatic model_reset();
    live       = 1'b0;
    shown      = 6'd0;
    shown_step = 0;
    m_skip     = 1'b0;
    m_step     = 3'd0;
    m_dir      = 1'b0;
    m_en       = 1'b0;
  endtask

  // One clock edge of the model. m_* hold the registered inputs seen by the
  // edge; they are refreshed from the live inputs afterwards.
  task automatic model_edge();
    cyc++;
    if (!m_en || m_step >= 3'd6) begin
      live  = 1'b0;
      shown = 6'd0;
    end else if (!live) begin
      live        = 1'b1;
      release_cyc = cyc + D;
      shown       = 6'd0;
    end else if (cyc == release_cyc) begin
      shown      = ref_pattern(int'(m_step), m_dir);
      shown_step = int'(m_step);
    end else if (cyc > release_cyc) begin
      if (int'(m_step) != shown_step && !ref_adjacent(shown_step, int'(m_step)))
        m_skip = 1'b1;
      if (ref_pattern(int'(m_step), m_dir) != shown) begin
        release_cyc = cyc + D;
        shown       = 6'd0;
      end
    end
    m_step = step;
    m_dir  = dir;
    m_en   = en;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare all outputs with the model on the falling edge.
  task automatic cycle_check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("hi", 6'(hi), 6'(shown[5:3]));
    chk("lo", 6'(lo), 6'(shown[2:0]));
    chk("no_overlap", 6'(hi & lo), 6'd0);
    chk("busy", 6'(busy), 6'(live && (cyc < release_cyc)));
    chk("err_invalid", 6'(err_invalid), 6'(m_step >= 3'd6));
`ifdef COMMUT_SKIP_CHECK_EN
    chk("err_skip", 6'(err_skip), 6'(m_skip));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_hi", 6'(hi), 6'd0);
    chk("async_rst_lo", 6'(lo), 6'd0);
    chk("async_rst_busy", 6'(busy), 6'd0);
    chk("async_rst_err_invalid", 6'(err_invalid), 6'd0);
`ifdef COMMUT_SKIP_CHECK_EN
    chk("async_rst_err_skip", 6'(err_skip), 6'd0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  int zero_cnt;
  int busy_cnt;
  int inv_cnt;
  int hold;

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    step  = 3'd0;
    dir   = 1'b0;
    model_reset();
    #2;
    chk("reset_hi", 6'(hi), 6'd0);
    chk("reset_lo", 6'(lo), 6'd0);
    chk("reset_busy", 6'(busy), 6'd0);
    chk("reset_err_invalid", 6'(err_invalid), 6'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Plan 1: start-up from OFF at step 0.
    en   = 1'b1;
    step = 3'd0;
    zero_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < D + 1; i++) begin
      cycle_check();
      if (hi == 3'd0 && lo == 3'd0) zero_cnt++;
      if (busy) busy_cnt++;
    end
    cycle_check();
    chk("p1_zero_cycles", 6'(zero_cnt), 6'(D + 1));
    chk("p1_busy_cycles", 6'(busy_cnt), 6'(D));
    chk("p1_hi", 6'(hi), 6'b000001);
    chk("p1_lo", 6'(lo), 6'b000010);
    $display("txn plan1 step=0 hi=%b lo=%b", hi, lo);

    // Plan 2: step 1 then step 2.
    step = 3'd1;
    run(D + 2);
    step = 3'd2;
    run(D + 2);
    chk("p2_hi", 6'(hi), 6'b000010);
    chk("p2_lo", 6'(lo), 6'b000100);
    $display("txn plan2 step=2 hi=%b lo=%b", hi, lo);

    // Plan 3: single-cycle glitch to step 6 while running at step 5.
    step = 3'd5;
    run(D + 2);
    step = 3'd6;
    cycle_check();
    inv_cnt = err_invalid ? 1 : 0;
    step = 3'd5;
    for (int i = 0; i < D + 2; i++) begin
      cycle_check();
      if (err_invalid) inv_cnt++;
    end
    chk("p3_invalid_cycles", 6'(inv_cnt), 6'd1);
    chk("p3_hi", 6'(hi), 6'b000100);
    chk("p3_lo", 6'(lo), 6'b000010);
    $display("txn plan3 glitch step=6 hi=%b lo=%b", hi, lo);

    // Plan 4: reverse at step 3, then disable.
    step = 3'd3;
    run(D + 2);
    dir = 1'b1;
    run(D + 2);
    chk("p4_hi", 6'(hi), 6'b000001);
    chk("p4_lo", 6'(lo), 6'b000010);
    en = 1'b0;
    run(2);
    chk("p4_off_hi", 6'(hi), 6'd0);
    chk("p4_off_lo", 6'(lo), 6'd0);
    $display("txn plan4 dir=1 then en=0 hi=%b lo=%b", hi, lo);

    // Plan 6: asynchronous reset in the middle of DEAD, then full recovery.
    en   = 1'b1;
    dir  = 1'b0;
    step = 3'd4;
    run(3);
    chk("p6_mid_dead_busy", 6'(busy), 6'd1);
    async_reset_pulse();
    run(D + 2);
    chk("p6_hi", 6'(hi), 6'b000100);
    chk("p6_lo", 6'(lo), 6'b000001);
    $display("txn plan6 reset mid-dead, recovered hi=%b lo=%b", hi, lo);

    // Plan 5: adjacency checking 4 -> 5 -> 0 then a 0 -> 2 jump.
    step = 3'd5;
    run(D + 2);
    step = 3'd0;
    run(D + 2);
`ifdef COMMUT_SKIP_CHECK_EN
    chk("p5_no_skip", 6'(err_skip), 6'd0);
`endif
    step = 3'd2;
    run(D + 2);
`ifdef COMMUT_SKIP_CHECK_EN
    chk("p5_skip_set", 6'(err_skip), 6'd1);
`endif
    chk("p5_hi", 6'(hi), 6'b000010);
    chk("p5_lo", 6'(lo), 6'b000100);
    async_reset_pulse();
    $display("txn plan5 4-5-0-2 sequence done hi=%b lo=%b", hi, lo);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 99) < 85) step = 3'($urandom_range(0, 5));
      else                            step = 3'($urandom_range(6, 7));
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      en   = ($urandom_range(0, 99) < 95);
      hold = $urandom_range(1, D + 3);
      $display("txn %0d step=%0d dir=%0d en=%0d hold=%0d", t, step, dir, en, hold);
      run(hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
